// File: rtl/move_history.sv
// Undo store and net step counter for the Sokoban core: a circular record
// stack that silently drops its oldest entry when full.
module move_history #(
   parameter int DEPTH    = 16,
   parameter int PTR_W    = 4,
   parameter int STEP_MAX = 999
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             step_inc,
   input  logic             step_dec,
   input  logic [8:0]       rec_in,
   output logic             real_retract,
   output logic [8:0]       top_rec,
   output logic [PTR_W:0]   depth,
   output logic [9:0]       step_count,
   output logic             underflow,
   output logic             conflict
);

   localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [9:0]     SAT_MAX = 10'(STEP_MAX);

   logic [8:0]       mem [DEPTH];
   logic [PTR_W-1:0] wp, wp_nxt;
   logic [PTR_W:0]   cnt, cnt_nxt;
   logic [9:0]       sc_nxt;
   logic [8:0]       top_nxt;
   logic             uf_nxt, cf_nxt, we;
   logic [PTR_W-1:0] wp_m2;

   assign wp_m2 = wp - PTR_W'(2);
   assign depth = cnt;

   always_comb begin
      wp_nxt  = wp;
      cnt_nxt = cnt;
      sc_nxt  = step_count;
      top_nxt = top_rec;
      uf_nxt  = underflow;
      cf_nxt  = conflict;
      we      = 1'b0;
      if (clear) begin
         wp_nxt  = '0;
         cnt_nxt = '0;
         sc_nxt  = '0;
         top_nxt = '0;
         uf_nxt  = 1'b0;
         cf_nxt  = 1'b0;
      end else if (step_inc && step_dec) begin
         cf_nxt = 1'b1;
      end else if (step_inc) begin
         we      = 1'b1;
         wp_nxt  = wp + PTR_W'(1);
         top_nxt = rec_in;
         if (cnt != FULL) cnt_nxt = cnt + (PTR_W+1)'(1);
         if (step_count < SAT_MAX) sc_nxt = step_count + 10'd1;
      end else if (step_dec) begin
         if (cnt != '0) begin
            wp_nxt  = wp - PTR_W'(1);
            cnt_nxt = cnt - (PTR_W+1)'(1);
            if (step_count != '0) sc_nxt = step_count - 10'd1;
            // The record below the current top becomes the new top.
            top_nxt = (cnt >= (PTR_W+1)'(2)) ? mem[wp_m2] : 9'd0;
         end else begin
            uf_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp           <= '0;
         cnt          <= '0;
         step_count   <= '0;
         top_rec      <= '0;
         underflow    <= 1'b0;
         conflict     <= 1'b0;
         real_retract <= 1'b0;
      end else begin
         wp           <= wp_nxt;
         cnt          <= cnt_nxt;
         step_count   <= sc_nxt;
         top_rec      <= top_nxt;
         underflow    <= uf_nxt;
         conflict     <= cf_nxt;
         real_retract <= (cnt_nxt != '0);
      end
   end

   // Storage needs no reset; cnt alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (we) mem[wp] <= rec_in;
   end

endmodule

// File: tb/tb_move_history.sv
// Randomised scoreboard bench for move_history against a queue-based model.
module tb_move_history;

   localparam int DEPTH    = 16;
   localparam int PTR_W    = 4;
   localparam int STEP_MAX = 999;
   localparam int VW       = 27;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             clear = 1'b0;
   logic             step_inc = 1'b0;
   logic             step_dec = 1'b0;
   logic [8:0]       rec_in = '0;
   logic             real_retract;
   logic [8:0]       top_rec;
   logic [PTR_W:0]   depth;
   logic [9:0]       step_count;
   logic             underflow;
   logic             conflict;

   logic [VW-1:0] exp_q[$];
   logic [8:0]    hist[$];
   int            m_sc;
   logic          m_uf, m_cf;
   int            tests = 0;
   int            fails = 0;

   move_history #(.DEPTH(DEPTH), .PTR_W(PTR_W), .STEP_MAX(STEP_MAX)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .step_inc(step_inc),
      .step_dec(step_dec), .rec_in(rec_in), .real_retract(real_retract),
      .top_rec(top_rec), .depth(depth), .step_count(step_count),
      .underflow(underflow), .conflict(conflict)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] dut_vec();
      return {real_retract, top_rec, depth, step_count, underflow, conflict};
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [8:0] top;
      top = (hist.size() > 0) ? hist[hist.size()-1] : 9'd0;
      return {hist.size() > 0, top, (PTR_W+1)'(hist.size()), 10'(m_sc), m_uf, m_cf};
   endfunction

   task automatic model_reset();
      hist.delete();
      m_sc = 0;
      m_uf = 1'b0;
      m_cf = 1'b0;
   endtask

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got rr=%0b top=%h depth=%0d sc=%0d uf=%0b cf=%0b, expected rr=%0b top=%h depth=%0d sc=%0d uf=%0b cf=%0b",
                  name, got[26], got[25:17], got[16:12], got[11:2], got[1], got[0],
                  exp[26], exp[25:17], exp[16:12], exp[11:2], exp[1], exp[0]);
      end
   endtask

   // Driver: one cycle of strobes; the model's post-edge view goes to the scoreboard.
   task automatic step(input logic inc, input logic dec, input logic clr, input logic [8:0] rec);
      @(negedge clk);
      step_inc = inc;
      step_dec = dec;
      clear    = clr;
      rec_in   = rec;
      if (clr) begin
         model_reset();
      end else if (inc && dec) begin
         m_cf = 1'b1;
      end else if (inc) begin
         hist.push_back(rec);
         if (hist.size() > DEPTH) void'(hist.pop_front());
         if (m_sc < STEP_MAX) m_sc++;
      end else if (dec) begin
         if (hist.size() == 0) m_uf = 1'b1;
         else begin
            void'(hist.pop_back());
            if (m_sc > 0) m_sc--;
         end
      end
      exp_q.push_back(model_vec());
   endtask

   task automatic async_reset(input string name);
      @(negedge clk);
      step_inc = 1'b0;
      step_dec = 1'b0;
      clear    = 1'b0;
      #2 reset_n = 1'b0;
      #1 check(name, dut_vec(), '0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor: every registered output update is compared against the next expectation.
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", dut_vec(), exp_q.pop_front());
   end

   initial begin
      model_reset();
      #2 reset_n = 1'b0;
      #1 check("reset", dut_vec(), '0);
      @(negedge clk);
      reset_n = 1'b1;

      repeat (5) step(0, 0, 0, 9'h0);

      step(1, 0, 0, 9'h0A5);
      step(1, 0, 0, 9'h123);
      step(1, 0, 0, 9'h1FF);
      repeat (4) step(0, 1, 0, 9'h0);

      step(0, 0, 1, 9'h0);
      step(1, 0, 0, 9'h011);
      step(1, 0, 0, 9'h022);
      step(1, 1, 0, 9'h033);
      step(0, 0, 1, 9'h0);
      step(1, 0, 1, 9'h044);
      step(0, 0, 0, 9'h0);

      for (int i = 1; i <= DEPTH + 4; i++) step(1, 0, 0, 9'(i));
      repeat (DEPTH + 1) step(0, 1, 0, 9'h0);
      step(0, 0, 1, 9'h0);

      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2)       step(0, 0, 1, 9'($urandom));
         else if (r < 6)  step(1, 1, 0, 9'($urandom));
         else if (r < 52) step(1, 0, 0, 9'($urandom));
         else if (r < 92) step(0, 1, 0, 9'($urandom));
         else             step(0, 0, 0, 9'($urandom));
      end

      step(0, 0, 1, 9'h0);
      for (int i = 0; i < 1005; i++) step(1, 0, 0, 9'($urandom));
      step(0, 1, 0, 9'h0);
      step(1, 0, 0, 9'h155);
      async_reset("async_reset");
      step(0, 0, 0, 9'h0);
      step(1, 0, 0, 9'h0AB);
      step(0, 0, 0, 9'h0);

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
